decoder_stage_controller: RTL and testbench

- Central sequencer for the processing-unit array. Drives the `global_stage` broadcast that every processing unit registers.
- Watches the array's per-PU `busy` and `odd` outputs. Uses them to decide when merge has converged, whether another grow round is needed, and when peeling has finished.
- Sits directly upstream of the PE array; its `global_stage` output is the PEs' `global_stage` input.
- Reports result-valid to the readout logic and holds it until acknowledged.

---
 rtl/decoder_stage_controller_pkg.sv | 26 ++
 rtl/decoder_stage_controller_stage_quiet_detector.sv | 51 +++++
 rtl/decoder_stage_controller.sv | 116 +++++++++++
 tb/tb_decoder_stage_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encoding and helpers for the decoder stage sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH     = 3;
  // Width of the per-stage dwell counter; saturates, so only needs to cover
  // the longest fixed dwell plus the settle window.
  localparam int STAGE_CNT_WIDTH = 8;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_PEELING             = 3'd4,
    STAGE_RESULT_VALID        = 3'd5
  } stage_e;

  // Stages during which the decode latency counter advances.
  function automatic logic is_counting_stage(input stage_e s);
    return (s == STAGE_MEASUREMENT_LOADING) || (s == STAGE_GROW) ||
           (s == STAGE_MERGE) || (s == STAGE_PEELING);
  endfunction

endpackage

// File: rtl/decoder_stage_controller_stage_quiet_detector.sv
// Tracks dwell time in the current stage and detects array quiescence.
// Latency: busy is registered once; quiet is combinational from registered state.
// Backpressure: none; samples busy every cycle.
module stage_quiet_detector
  import decoder_stage_controller_pkg::*;
#(
  parameter int PU_COUNT      = 64,
  parameter int SETTLE_CYCLES = 3,
  parameter int QUIET_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stage_change,
  input  logic [PU_COUNT-1:0]        busy,
  output logic [STAGE_CNT_WIDTH-1:0] stage_cnt,
  output logic                       quiet
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);

  logic          any_busy_q;
  logic [QW-1:0] quiet_cnt;
  logic          settled;

  // Quiet counting only begins once the PUs have had time to react to the new stage.
  assign settled = (stage_cnt >= STAGE_CNT_WIDTH'(SETTLE_CYCLES));

  // Pulse on the sample that completes the required run of not-busy samples.
  assign quiet = settled && !any_busy_q && (quiet_cnt == QW'(QUIET_CYCLES - 1));

  // Register the array-wide busy OR so decisions never see raw array outputs.
  always_ff @(posedge clk) begin
    if (reset) any_busy_q <= 1'b0;
    else       any_busy_q <= |busy;
  end

  // Dwell counter: restarts on every stage change, saturates otherwise.
  always_ff @(posedge clk) begin
    if (reset || stage_change)  stage_cnt <= '0;
    else if (stage_cnt != '1)   stage_cnt <= stage_cnt + 1'b1;
  end

  // Consecutive not-busy counter; any busy sample or stage change restarts it.
  always_ff @(posedge clk) begin
    if (reset || stage_change || any_busy_q)
      quiet_cnt <= '0;
    else if (settled && (quiet_cnt != QW'(QUIET_CYCLES)))
      quiet_cnt <= quiet_cnt + 1'b1;
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// Central stage sequencer broadcasting global_stage to the PU array.
// Latency: stage register drives global_stage directly; decisions use 1-cycle registered array status.
// Backpressure: start taken only in IDLE; result held in RESULT_VALID until result_ack.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int PU_COUNT      = 64,
  parameter int MAX_ITER      = 31,
  parameter int ITER_WIDTH    = 5,
  parameter int CYCLE_WIDTH   = 16,
  parameter int LOAD_CYCLES   = 2,
  parameter int GROW_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 3,
  parameter int QUIET_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PU_COUNT-1:0]    busy,
  input  logic [PU_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   ready,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   overflow
);

  stage_e                     state;
  stage_e                     next_state;
  logic                       any_odd_q;
  logic                       stage_change;
  logic [STAGE_CNT_WIDTH-1:0] stage_cnt;
  logic                       quiet;
  logic                       at_max_iter;

  assign global_stage = state;
  assign at_max_iter  = (iteration_count == ITER_WIDTH'(MAX_ITER));
  assign stage_change = (next_state != state);

  stage_quiet_detector #(
    .PU_COUNT      (PU_COUNT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .QUIET_CYCLES  (QUIET_CYCLES)
  ) u_quiet (
    .clk          (clk),
    .reset        (reset),
    .stage_change (stage_change),
    .busy         (busy),
    .stage_cnt    (stage_cnt),
    .quiet        (quiet)
  );

  // Register the array-wide odd OR alongside the busy OR.
  always_ff @(posedge clk) begin
    if (reset) any_odd_q <= 1'b0;
    else       any_odd_q <= |odd;
  end

  // Next-stage decision; MERGE and PEELING both leave on the shared quiet pulse.
  always_comb begin
    next_state = state;
    case (state)
      STAGE_IDLE:
        if (start) next_state = STAGE_MEASUREMENT_LOADING;
      STAGE_MEASUREMENT_LOADING:
        if (stage_cnt >= STAGE_CNT_WIDTH'(LOAD_CYCLES - 1)) next_state = STAGE_MERGE;
      STAGE_GROW:
        if (stage_cnt >= STAGE_CNT_WIDTH'(GROW_CYCLES - 1)) next_state = STAGE_MERGE;
      STAGE_MERGE:
        if (quiet) begin
          if (!any_odd_q || at_max_iter) next_state = STAGE_PEELING;
          else                           next_state = STAGE_GROW;
        end
      STAGE_PEELING:
        if (quiet) next_state = STAGE_RESULT_VALID;
      STAGE_RESULT_VALID:
        if (result_ack) next_state = STAGE_IDLE;
      default:
        next_state = STAGE_IDLE;
    endcase
  end

  // Stage register, registered status flags and per-decode counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= STAGE_IDLE;
      ready           <= 1'b1;
      result_valid    <= 1'b0;
      iteration_count <= '0;
      cycle_count     <= '0;
      overflow        <= 1'b0;
    end else begin
      state        <= next_state;
      ready        <= (next_state == STAGE_IDLE);
      result_valid <= (next_state == STAGE_RESULT_VALID);

      if ((state == STAGE_IDLE) && start) begin
        iteration_count <= '0;
        cycle_count     <= '0;
        overflow        <= 1'b0;
      end

      if (is_counting_stage(state) && (cycle_count != '1))
        cycle_count <= cycle_count + 1'b1;

      // Odd clusters remain at convergence: grow again, or give up at the round limit.
      if ((state == STAGE_MERGE) && quiet && any_odd_q) begin
        if (at_max_iter) overflow        <= 1'b1;
        else             iteration_count <= iteration_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Bench for decoder_stage_controller: directed vectors plus a lockstep reference model.
module tb_decoder_stage_controller;

  localparam int PU     = 4;
  localparam int MAXI   = 3;
  localparam int LOADC  = 2;
  localparam int GROWC  = 1;
  localparam int SETTLE = 3;
  localparam int QUIET  = 2;

  localparam int S_IDLE = 0, S_LOAD = 1, S_GROW = 2, S_MERGE = 3, S_PEEL = 4, S_RV = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PU-1:0] busy;
  logic [PU-1:0] odd;
  logic [2:0]    global_stage;
  logic          ready;
  logic          result_valid;
  logic          result_ack;
  logic [4:0]    iteration_count;
  logic [15:0]   cycle_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  decoder_stage_controller #(
    .PU_COUNT (PU),
    .MAX_ITER (MAXI)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .odd             (odd),
    .global_stage    (global_stage),
    .ready           (ready),
    .result_valid    (result_valid),
    .result_ack      (result_ack),
    .iteration_count (iteration_count),
    .cycle_count     (cycle_count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input int s, input int budget);
    int n;
    n = 0;
    while (global_stage !== 3'(s) && n < budget) begin
      tick();
      n++;
    end
    check("wait_stage", global_stage, s);
  endtask

  // ---------------- reference model ----------------
  // Works from the rules directly: a stage is left when enough cycles have
  // elapsed since entry, or when the last QUIET registered busy samples were
  // all clear and all lay past the settle window.
  int t = 0;
  bit bo[65536];
  bit oo[65536];
  int m_stage = 0, m_entry = 0, m_iter = 0, m_cyc = 0;
  bit m_ov = 1'b0;

  function automatic bit quiet_now(input int tt);
    for (int k = 0; k < QUIET; k++) begin
      int c;
      c = tt - k;
      if (c - m_entry < SETTLE) return 1'b0;
      if (bo[(c - 1) % 65536]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int nxt;
    bo[t % 65536] = reset ? 1'b0 : |busy;
    oo[t % 65536] = reset ? 1'b0 : |odd;
    if (reset) begin
      m_stage = S_IDLE; m_iter = 0; m_cyc = 0; m_ov = 1'b0; m_entry = t + 1;
    end else begin
      nxt = m_stage;
      if (m_stage >= S_LOAD && m_stage <= S_PEEL && m_cyc < 65535) m_cyc++;
      case (m_stage)
        S_IDLE:  if (start) begin nxt = S_LOAD; m_iter = 0; m_cyc = 0; m_ov = 1'b0; end
        S_LOAD:  if (t - m_entry + 1 >= LOADC) nxt = S_MERGE;
        S_GROW:  if (t - m_entry + 1 >= GROWC) nxt = S_MERGE;
        S_MERGE: if (quiet_now(t)) begin
                   if (!oo[(t - 1) % 65536]) nxt = S_PEEL;
                   else if (m_iter == MAXI) begin nxt = S_PEEL; m_ov = 1'b1; end
                   else begin nxt = S_GROW; m_iter++; end
                 end
        S_PEEL:  if (quiet_now(t)) nxt = S_RV;
        S_RV:    if (result_ack) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
      if (nxt != m_stage) begin m_stage = nxt; m_entry = t + 1; end
    end
    t++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_stage", global_stage, m_stage);
      check("m_ready", ready, (m_stage == S_IDLE));
      check("m_rvalid", result_valid, (m_stage == S_RV));
      check("m_iter", iteration_count, m_iter);
      check("m_cycles", cycle_count, m_cyc);
      check("m_ovf", overflow, m_ov);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [PU-1:0] odd_pat;
    int            clear_after;  // MERGE exits before odd drops to zero
    int            exp_iter;
    bit            exp_ov;
    int            exp_cyc;
  } vec_t;

  vec_t vt[5];
  int   zexp[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b0000, 0,  0, 1'b0, 12};
    vt[1] = '{4'b0011, 2,  2, 1'b0, 24};
    vt[2] = '{4'b0001, 99, 3, 1'b1, 30};
    vt[3] = '{4'b1000, 1,  1, 1'b0, 18};
    vt[4] = '{4'b0100, 3,  3, 1'b0, 30};
    zexp  = '{1, 1, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4, 5};

    reset = 1'b1; start = 1'b0; busy = '0; odd = '0; result_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_stage", global_stage, S_IDLE);
    check("rst_ready", ready, 1);
    check("rst_rvalid", result_valid, 0);
    check("rst_iter", iteration_count, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_ovf", overflow, 0);
    chk_en = 1'b1;

    // Zero-defect decode: exact stage sequence and result hold.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      check("zd_seq", global_stage, zexp[i]);
      if (i < 12) tick();
    end
    check("zd_cycles", cycle_count, 12);
    check("zd_iter", iteration_count, 0);
    check("zd_ovf", overflow, 0);
    repeat (3) tick();
    check("zd_hold_rv", result_valid, 1);
    check("zd_hold_cyc", cycle_count, 12);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("zd_ack_idle", global_stage, S_IDLE);
    check("zd_ack_ready", ready, 1);

    // Table rows: odd held until a chosen number of MERGE exits.
    for (int i = 0; i < 5; i++) begin
      int exits, n, prev;
      if (i > 0 && vt[i-1].exp_ov) check("tv_ovf_sticky", overflow, 1);
      start = 1'b1; odd = vt[i].odd_pat; tick(); start = 1'b0;
      check("tv_ovf_cleared", overflow, 0);
      check("tv_iter_cleared", iteration_count, 0);
      exits = 0; n = 0; prev = global_stage;
      while (global_stage !== 3'(S_RV) && n < 300) begin
        tick(); n++;
        if (prev == S_MERGE && global_stage != 3'(S_MERGE)) begin
          exits++;
          if (exits == vt[i].clear_after) odd = '0;
        end
        prev = global_stage;
      end
      check("tv_done", global_stage, S_RV);
      check("tv_iter", iteration_count, vt[i].exp_iter);
      check("tv_ovf", overflow, vt[i].exp_ov);
      check("tv_cycles", cycle_count, vt[i].exp_cyc);
      result_ack = 1'b1; tick(); result_ack = 1'b0; odd = '0;
    end

    // Late busy: busy seen during MERGE cycles 3..5 postpones exit to cycle 9.
    start = 1'b1; tick(); start = 1'b0;
    wait_stage(S_MERGE, 10);
    repeat (3) tick();
    busy = 4'b0100;
    repeat (3) tick();
    busy = '0;
    check("late_m6", global_stage, S_MERGE);
    tick(); tick();
    check("late_m8", global_stage, S_MERGE);
    tick();
    check("late_exit", global_stage, S_PEEL);
    wait_stage(S_RV, 20);
    result_ack = 1'b1; tick(); result_ack = 1'b0;

    // Reset while in GROW.
    start = 1'b1; odd = 4'b0001; tick(); start = 1'b0;
    wait_stage(S_GROW, 30);
    reset = 1'b1; tick(); reset = 1'b0; odd = '0;
    check("rg_stage", global_stage, S_IDLE);
    check("rg_cycles", cycle_count, 0);
    check("rg_iter", iteration_count, 0);
    check("rg_ready", ready, 1);

    // start during PEELING and RESULT_VALID is ignored.
    start = 1'b1; tick(); start = 1'b0;
    wait_stage(S_PEEL, 20);
    start = 1'b1; tick(); start = 1'b0;
    check("peel_start_ign", global_stage, S_PEEL);
    wait_stage(S_RV, 10);
    start = 1'b1; tick(); tick(); start = 1'b0;
    check("rv_start_ign", global_stage, S_RV);
    check("rv_cycles", cycle_count, 12);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("rv_ack_idle", global_stage, S_IDLE);

    // Randomized decodes checked cycle-by-cycle against the model.
    for (int d = 0; d < 60; d++) begin
      int mode, n;
      mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) begin
        result_ack = ($urandom_range(0, 1) == 1);
        busy = 4'($urandom_range(0, 15));
        tick();
      end
      result_ack = 1'b0; busy = '0;
      wait_stage(S_IDLE, 5);
      start = 1'b1;
      odd = (mode == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tick();
      start = 1'b0;
      n = 0;
      while (global_stage !== 3'(S_RV) && global_stage !== 3'(S_IDLE) && n < 800) begin
        busy = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        if (mode == 1) odd = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        start      = ($urandom_range(0, 4) == 0);
        result_ack = ($urandom_range(0, 4) == 0);
        reset      = ($urandom_range(0, 299) == 0);
        tick();
        n++;
      end
      start = 1'b0; reset = 1'b0; result_ack = 1'b0; busy = '0; odd = '0;
      check("rand_budget", (n < 800), 1);
      if (global_stage == 3'(S_RV)) begin
        repeat ($urandom_range(0, 3)) tick();
        result_ack = 1'b1; tick(); result_ack = 1'b0;
      end
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
